// File: rtl/bresenham_arbiter.sv
// Round-robin front end for the shared Bresenham line engine: grants one
// requester at a time, latches its endpoints and waits for draw_done or a watchdog.
module bresenham_arbiter_port #(
   parameter int OW  = 2,
   parameter int IDX = 0
) (
   input  logic [OW-1:0] owner,
   input  logic          issue,
   input  logic          retire,
   output logic          gnt,
   output logic          done
);
   logic hit;
   assign hit  = (owner == OW'(IDX));
   assign gnt  = issue & hit;
   assign done = retire & hit;
endmodule

module bresenham_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 512
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0][31:0]   req_coords,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         done,
   output logic                       err,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic [7:0]                 x0,
   output logic [7:0]                 y0,
   output logic [7:0]                 x1,
   output logic [7:0]                 y1,
   output logic                       draw_en,
   input  logic                       draw_done
);
   localparam int OW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETIRE} state_t;

   state_t          state, state_nx;
   logic [OW-1:0]   last_owner;
   logic [OW-1:0]   win, cand;
   logic            win_vld;
   logic [CW-1:0]   cnt;
   logic            to_flag;
   logic            cnt_last;

   // Walk downward so the candidate closest after last_owner is assigned last and wins.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      cand    = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = OW'((int'(last_owner) + i) % NUM_REQ);
         if (req[cand]) begin
            win     = cand;
            win_vld = 1'b1;
         end
      end
   end

   // The RETIRE cycle lands exactly TIMEOUT cycles after ISSUE.
   assign cnt_last = (cnt == CW'(TIMEOUT - 2));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (win_vld) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (draw_done || cnt_last) state_nx = RETIRE;
         RETIRE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= OW'(NUM_REQ - 1);
         {x0, y0, x1, y1} <= '0;
         cnt        <= '0;
         to_flag    <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (win_vld) begin
               owner            <= win;
               {x0, y0, x1, y1} <= req_coords[win];
            end
            ISSUE: cnt <= '0;
            WAIT: begin
               if (draw_done)     to_flag <= 1'b0;
               else if (cnt_last) to_flag <= 1'b1;
               else               cnt     <= cnt + 1'b1;
            end
            RETIRE: last_owner <= owner;
            default: ;
         endcase
      end
   end

   assign busy    = (state != IDLE);
   assign draw_en = (state == ISSUE);
   assign err     = (state == RETIRE) & to_flag;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
      bresenham_arbiter_port #(.OW(OW), .IDX(g)) u_port (
         .owner  (owner),
         .issue  (state == ISSUE),
         .retire (state == RETIRE),
         .gnt    (gnt[g]),
         .done   (done[g])
      );
   end
endmodule

// File: tb/tb_bresenham_arbiter.sv
// Scoreboard bench for bresenham_arbiter: expected grants are queued as requests are
// raised; the monitor pops them on gnt, acts as the line engine and checks done/err timing.
module tb_bresenham_arbiter;
   localparam int NR = 4;
   localparam int TO = 8;

   logic              clk, rst;
   logic [NR-1:0]     req;
   logic [NR*32-1:0]  req_coords;
   logic [NR-1:0]     gnt, done;
   logic              err, busy, draw_en, draw_done;
   logic [1:0]        owner;
   logic [7:0]        x0, y0, x1, y1;

   bresenham_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_coords(req_coords),
      .gnt(gnt), .done(done), .err(err), .busy(busy), .owner(owner),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .draw_en(draw_en), .draw_done(draw_done)
   );

   typedef struct { int idx; logic [31:0] coords; int lat; bit after_done; } gnt_t;
   typedef struct { int idx; bit err; int cyc; } done_t;

   gnt_t  gq[$];
   done_t dq[$];
   int n_chk = 0, n_fail = 0;
   int cyc = 0, gnt_seen = 0, k = -1, cur_lat = -1, last_done = -100;
   bit post_done = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor + line-engine model; draw_done is raised lat cycles after the ISSUE cycle.
   always @(negedge clk) begin
      gnt_t  g;
      done_t d;
      bit    e_err;
      if (rst) begin
         chk("rst_outs", {gnt, done, err, busy, draw_en, owner, x0, y0, x1, y1}, 64'd0);
         k = -1; draw_done = 1'b0; post_done = 0;
      end else begin
         if (post_done) begin chk("busy_after_done", busy, 0); post_done = 0; end
         if (k >= 0) k++;
         if (gnt != 0) begin
            gnt_seen++;
            if (gq.size() == 0) chk("gnt_unexpected", gnt, 0);
            else begin
               g = gq.pop_front();
               chk("gnt", gnt, 64'd1 << g.idx);
               chk("owner", owner, g.idx);
               chk("draw_en", draw_en, 1);
               chk("coords", {x0, y0, x1, y1}, g.coords);
               if (g.after_done) chk("gnt_cycle", cyc, last_done + 2);
               e_err = (g.lat < 1 || g.lat > TO - 1);
               d.idx = g.idx; d.err = e_err;
               d.cyc = e_err ? cyc + TO : cyc + g.lat + 1;
               dq.push_back(d);
               cur_lat = g.lat; k = 0;
            end
         end else chk("draw_en_nogrant", draw_en, 0);
         if (done != 0) begin
            if (dq.size() == 0) chk("done_unexpected", done, 0);
            else begin
               d = dq.pop_front();
               chk("done", done, 64'd1 << d.idx);
               chk("err", err, d.err);
               chk("done_cycle", cyc, d.cyc);
            end
            last_done = cyc; post_done = 1;
         end else chk("err_without_done", err, 0);
         draw_done = (k >= 0 && k == cur_lat);
      end
   end

   task automatic step();
      @(negedge clk); #1;
   endtask

   task automatic req_line(input int idx, input logic [31:0] c, input int lat, input bit ad);
      gnt_t g;
      req_coords[idx*32 +: 32] = c;
      req[idx] = 1'b1;
      g.idx = idx; g.coords = c; g.lat = lat; g.after_done = ad;
      gq.push_back(g);
   endtask

   task automatic wait_gnt(input int n);
      int t = 0;
      while (gnt_seen < n && t < 100) begin step(); t++; end
      if (t >= 100) chk("gnt_wait_expired", gnt_seen, n);
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((gq.size() != 0 || dq.size() != 0 || busy) && t < 200) begin step(); t++; end
      if (t >= 200) chk("idle_wait_expired", gq.size() + dq.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0;
      step(); step();
      rst = 1'b0;
   endtask

   initial begin
      int base;
      draw_done = 1'b0;
      rst = 1'b1; req = '1; req_coords = '0;
      step(); step();
      rst = 1'b0; req = '0;
      step();
      chk("release_busy", busy, 0);
      chk("release_gnt", gnt, 0);

      // single line, coords latched across requester changes
      req_line(1, 32'h0A141E28, 5, 0);
      wait_gnt(gnt_seen + 1);
      req = '0; req_coords[32 +: 32] = 32'hFFFFFFFF;
      step();
      chk("latched_x0", x0, 8'h0A);
      chk("latched_y1", y1, 8'h28);
      wait_idle();

      // round robin from reset priority with all requesters held
      do_reset();
      for (int i = 0; i < NR; i++) req_coords[i*32 +: 32] = 32'h11121314 + i * 32'h10101010;
      for (int i = 0; i < 5; i++) req_line(i % NR, 32'h11121314 + (i % NR) * 32'h10101010, 3, i > 0);
      base = gnt_seen;
      req = '1;
      wait_gnt(base + 5);
      req = '0;
      wait_idle();

      // timeout, plus a request raised mid-WAIT that must wait for RETIRE
      req_line(2, 32'hC0C1C2C3, -1, 0);
      wait_gnt(gnt_seen + 1);
      req = '0;
      step(); step(); step();
      chk("timeout_busy", busy, 1);
      req_line(3, 32'hD0D1D2D3, 2, 1);
      wait_gnt(gnt_seen + 1);
      req = '0;
      wait_idle();

      // draw_done coincident with the last timeout cycle
      req_line(1, 32'hE0E1E2E3, TO - 1, 0);
      wait_gnt(gnt_seen + 1);
      req = '0;
      wait_idle();

      // draw_done in the ISSUE cycle is ignored
      req_line(0, 32'hF0F1F2F3, 0, 0);
      wait_gnt(gnt_seen + 1);
      req = '0;
      step();
      chk("issue_done_ignored_busy", busy, 1);
      wait_idle();

      // reset mid-WAIT: no done, priority returns to requester 0
      req_line(2, 32'hA0A1A2A3, -1, 0);
      wait_gnt(gnt_seen + 1);
      req = '0;
      step(); step();
      rst = 1'b1; dq.delete();
      step();
      rst = 1'b0;
      step();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", {done, err}, 0);
      req_coords[32 +: 32] = 32'h55565758;
      req_line(0, 32'h44454647, 1, 0);
      req[1] = 1'b1;
      wait_gnt(gnt_seen + 1);
      req = '0;
      wait_idle();

      chk("gq_empty", gq.size(), 0);
      chk("dq_empty", dq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/bresenham_arbiter.md
# bresenham_arbiter

Round-robin arbiter and sequencer that shares the single Bresenham line engine among up to NUM_REQ command sources (vertex sequencer, rectangle fill, host blit path, etc.). It accepts one line request at a time, latches its endpoints, issues a one-cycle start to the engine, and waits for completion or a watchdog timeout. It then returns a done pulse to the owning requester. It sits between the command front-end and the line engine's draw_en/draw_done handshake.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT, 512, max WAIT cycles before abort (≥2)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level
- req_coords  in  32*NUM_REQ  requester i at [32*i +: 32] = {x0[31:24], y0[23:16], x1[15:8], y1[7:0]}
- gnt  out  NUM_REQ  one-hot grant, high for exactly the ISSUE cycle
- done  out  NUM_REQ  one-hot completion pulse to owner, RETIRE cycle only
- err  out  1  high with done when the line ended by timeout
- busy  out  1  high in ISSUE, WAIT, RETIRE
- owner  out  clog2(NUM_REQ)  index of current/last granted requester
- x0, y0, x1, y1  out  8 each  latched endpoints driven to line engine
- draw_en  out  1  one-cycle start pulse to line engine
- draw_done  in  1  engine completion pulse

## Operation
- FSM states: IDLE, ISSUE, WAIT, RETIRE; reset state IDLE.
- IDLE: if req≠0 at an edge, select winner by round robin, searching upward from (last_owner+1) mod NUM_REQ with wrap. On the same edge, owner←winner, x0..y1←winner's req_coords slice, go ISSUE. req=0 → stay IDLE.
- ISSUE (1 cycle): gnt=onehot(owner), draw_en=1. Wait counter cleared. Next state WAIT unconditionally. draw_done is ignored in ISSUE.
- WAIT: draw_done=1 at edge → RETIRE, timeout flag←0. Otherwise counter+1. If counter reaches TIMEOUT−1 with no draw_done → RETIRE, timeout flag←1. draw_done wins over a coincident timeout.
- RETIRE (1 cycle): done=onehot(owner), err=timeout flag. last_owner←owner. Next state IDLE.
- req is sampled only in IDLE. Requests arriving in ISSUE/WAIT/RETIRE wait. A requester still asserting req in IDLE after its done is treated as a new request and competes normally.
- Requester holds req_coords stable while req is high until gnt. Coordinates may change from the gnt cycle on, because the arbiter holds its latched copy until the next grant.
- Counter width clog2(TIMEOUT); no wrap is reachable.
- Reset values: state IDLE, gnt=0, done=0, err=0, busy=0, draw_en=0, owner=0, x0=y0=x1=y1=0, last_owner=NUM_REQ−1, so requester 0 has first priority.
- Reset in any state: IDLE at the next edge, no done/err pulse. The owner's pending request is lost; the line engine is reset by the same rst.

## Timing
- Outputs gnt, draw_en, done, err, busy decode directly from registered state/owner/flag. No combinational path from req or draw_done to any output.
- req high at edge E → gnt and draw_en high in cycle E+1, with x0..y1 valid from E+1.
- draw_done high at edge D in WAIT → done/err high in cycle D+1 → IDLE at D+2. A new grant can be visible at D+3.
- Minimum per-line occupancy: 4 cycles (ISSUE, 1 WAIT, RETIRE, IDLE) plus engine latency.
- Timeout: with no draw_done, done+err are asserted exactly TIMEOUT cycles after the ISSUE cycle.
- busy low only in IDLE.

## Test plan
- Reset: rst high 2 cycles with req=4'hF → all outputs 0, busy=0, no gnt during reset or in the cycle after release.
- Single line: req=4'b0010, req_coords slice1=32'h0A141E28 → next cycle gnt=0010, draw_en=1, x0=0x0A, y0=0x14, x1=0x1E, y1=0x28. draw_done 5 cycles later → done=0010, err=0 one cycle, then busy=0.
- Round robin: req=4'hF held, draw_done 3 cycles after each draw_en → grant order 0001, 0010, 0100, 1000, 0001, with owner=0,1,2,3,0.
- Timeout (TIMEOUT=8): req=4'b0100, draw_done never asserted → done=0100 with err=1 exactly 8 cycles after the ISSUE cycle. Next pending request is then granted normally.
- Boundary events: draw_done pulsed in the ISSUE cycle → ignored, FSM stays in WAIT. req=4'b1000 raised mid-WAIT → not granted until after RETIRE. draw_done coincident with the last timeout cycle → err=0.
- Reset mid-WAIT: rst pulse during WAIT → IDLE next edge, no done/err pulse, last_owner=NUM_REQ−1, next request from requester 0 wins over requester 1.
